// File: rtl/tank_key_ctrl.sv
// Keyboard command controller for the two-player tank game: splits the shared keystroke
// stream into per-player move/fire pulses and owns the pause and restart controls.
module tank_key_ctrl #(
    parameter int unsigned MOVE_DIV      = 2_500_000,
    parameter int unsigned FIRE_COOLDOWN = 50_000_000
) (
    input  logic       clk_100mhz,
    input  logic       clrn,
    input  logic       press,
    input  logic [7:0] ascii,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir,
    output logic       p1_move,
    output logic       p2_move,
    output logic       p1_fire,
    output logic       p2_fire,
    output logic       paused,
    output logic       game_rst
);

    localparam int unsigned MoveW = $clog2(MOVE_DIV);
    localparam int unsigned CoolW = $clog2(FIRE_COOLDOWN + 1);
    localparam logic [MoveW-1:0] MoveLast = MoveW'(MOVE_DIV - 1);
    localparam logic [CoolW-1:0] CoolInit = CoolW'(FIRE_COOLDOWN);

    localparam logic [7:0] KeyPause   = 8'h70;
    localparam logic [7:0] KeyRestart = 8'h72;

    logic [8:0] r_s0;
    logic [8:0] r_s1;
    logic       r_paused;
    logic       r_game_rst;

    logic       w_event;
    logic       w_make;
    logic [7:0] w_code;
    logic       w_restart;
    logic       w_pause_tgl;

    // Typematic repeats leave s0 unchanged, so they never register as events.
    assign w_event     = (r_s0 != r_s1) && (r_s0[7:0] != 8'h00);
    assign w_make      = r_s0[8];
    assign w_code      = r_s0[7:0];
    assign w_restart   = w_event && w_make && (w_code == KeyRestart);
    assign w_pause_tgl = w_event && w_make && (w_code == KeyPause);

    function automatic logic [1:0] prio_dir(input logic [3:0] held);
        if (held[0]) begin
            return 2'd0;
        end else if (held[1]) begin
            return 2'd1;
        end else if (held[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    always_ff @(posedge clk_100mhz or negedge clrn) begin
        if (!clrn) begin
            r_s0 <= '0;
            r_s1 <= '0;
        end else begin
            r_s0 <= {press, ascii};
            r_s1 <= r_s0;
        end
    end

    always_ff @(posedge clk_100mhz or negedge clrn) begin
        if (!clrn) begin
            r_paused   <= 1'b0;
            r_game_rst <= 1'b0;
        end else if (w_restart) begin
            r_paused   <= 1'b0;
            r_game_rst <= 1'b1;
        end else begin
            r_game_rst <= 1'b0;
            if (w_pause_tgl) begin
                r_paused <= ~r_paused;
            end
        end
    end

    assign paused   = r_paused;
    assign game_rst = r_game_rst;

    for (genvar gp = 0; gp < 2; gp++) begin : g_player
        localparam logic [7:0] KeyUp    = (gp == 0) ? 8'h77 : 8'h69;
        localparam logic [7:0] KeyDown  = (gp == 0) ? 8'h73 : 8'h6B;
        localparam logic [7:0] KeyLeft  = (gp == 0) ? 8'h61 : 8'h6A;
        localparam logic [7:0] KeyRight = (gp == 0) ? 8'h64 : 8'h6C;
        localparam logic [7:0] KeyFire  = (gp == 0) ? 8'h20 : 8'h0D;

        logic [3:0]       r_held_dir;
        logic             r_held_fire;
        logic [1:0]       r_dir;
        logic [MoveW-1:0] r_cnt;
        logic [CoolW-1:0] r_cool;
        logic             r_move;
        logic             r_fire;

        logic [3:0]       w_held_dir_nx;
        logic             w_held_fire_nx;
        logic [1:0]       w_dir_nx;
        logic [MoveW-1:0] w_cnt_nx;
        logic [CoolW-1:0] w_cool_nx;
        logic             w_move_nx;
        logic             w_fire_nx;
        logic             w_is_dir;
        logic             w_is_fire;
        logic [1:0]       w_key_dir;

        always_comb begin
            w_is_dir  = 1'b0;
            w_is_fire = 1'b0;
            w_key_dir = 2'd0;
            if (w_event) begin
                if (w_code == KeyUp) begin
                    w_is_dir  = 1'b1;
                    w_key_dir = 2'd0;
                end else if (w_code == KeyDown) begin
                    w_is_dir  = 1'b1;
                    w_key_dir = 2'd1;
                end else if (w_code == KeyLeft) begin
                    w_is_dir  = 1'b1;
                    w_key_dir = 2'd2;
                end else if (w_code == KeyRight) begin
                    w_is_dir  = 1'b1;
                    w_key_dir = 2'd3;
                end else if (w_code == KeyFire) begin
                    w_is_fire = 1'b1;
                end
            end
        end

        always_comb begin
            w_held_dir_nx  = r_held_dir;
            w_held_fire_nx = r_held_fire;
            w_dir_nx       = r_dir;
            w_cnt_nx       = r_cnt;
            w_move_nx      = 1'b0;
            w_fire_nx      = 1'b0;
            w_cool_nx      = (r_cool != '0) ? r_cool - CoolW'(1) : r_cool;

            if (w_is_dir) begin
                w_held_dir_nx[w_key_dir] = w_make;
            end
            if (w_is_fire) begin
                w_held_fire_nx = w_make;
            end

            if (w_is_dir && w_make) begin
                w_dir_nx  = w_key_dir;
                w_cnt_nx  = '0;
                w_move_nx = ~r_paused;
            end else if (w_held_dir_nx == 4'b0000) begin
                w_cnt_nx = '0;
            end else begin
                // Releasing the facing key falls back to another held key without a pulse.
                if (w_is_dir && (r_dir == w_key_dir)) begin
                    w_dir_nx = prio_dir(w_held_dir_nx);
                end
                if (!r_paused) begin
                    if (r_cnt == MoveLast) begin
                        w_cnt_nx  = '0;
                        w_move_nx = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + MoveW'(1);
                    end
                end
            end

            if (w_is_fire && w_make && (r_cool == '0) && !r_paused) begin
                w_fire_nx = 1'b1;
                w_cool_nx = CoolInit;
            end
        end

        always_ff @(posedge clk_100mhz or negedge clrn) begin
            if (!clrn) begin
                r_held_dir  <= '0;
                r_held_fire <= 1'b0;
                r_dir       <= 2'd0;
                r_cnt       <= '0;
                r_cool      <= '0;
                r_move      <= 1'b0;
                r_fire      <= 1'b0;
            end else if (w_restart) begin
                r_held_dir  <= '0;
                r_held_fire <= 1'b0;
                r_dir       <= 2'd0;
                r_cnt       <= '0;
                r_cool      <= '0;
                r_move      <= 1'b0;
                r_fire      <= 1'b0;
            end else begin
                r_held_dir  <= w_held_dir_nx;
                r_held_fire <= w_held_fire_nx;
                r_dir       <= w_dir_nx;
                r_cnt       <= w_cnt_nx;
                r_cool      <= w_cool_nx;
                r_move      <= w_move_nx;
                r_fire      <= w_fire_nx;
            end
        end

        if (gp == 0) begin : g_out1
            assign p1_dir  = r_dir;
            assign p1_move = r_move;
            assign p1_fire = r_fire;
        end else begin : g_out2
            assign p2_dir  = r_dir;
            assign p2_move = r_move;
            assign p2_fire = r_fire;
        end
    end

endmodule

// File: doc/tank_key_ctrl.md
# tank_key_ctrl

Keyboard command controller for the two-player tank game. Consumes the registered `press`/`ascii` pair from the PS/2 keyboard decoder, turns the single shared keystroke stream into independent per-player command streams, and sits between the keyboard path and the game logic. It tracks held keys, paces movement with repeat ticks, rate-limits firing, and owns the pause and game-restart controls.

## Interface
- `MOVE_DIV`, 2_500_000: cycles between move pulses while a direction is held (40 Hz at 100 MHz); minimum 2.
- `FIRE_COOLDOWN`, 50_000_000: cycles after a fire pulse during which further fire presses are dropped; minimum 1.
- `clk_100mhz`  in  1  system clock.
- `clrn`  in  1  reset, asynchronous, active-low.
- `press`  in  1  from the keyboard decoder: 1 = make, 0 = break.
- `ascii`  in  8  from the keyboard decoder: key code; 0x00 = unmapped or no key.
- `p1_dir`, `p2_dir`  out  2  facing: 00 up, 01 down, 10 left, 11 right.
- `p1_move`, `p2_move`  out  1  one-cycle pulse: advance one step.
- `p1_fire`, `p2_fire`  out  1  one-cycle pulse: spawn a bullet.
- `paused`  out  1  level: game is paused.
- `game_rst`  out  1  one-cycle pulse: restart the game.

## Operation
- **Key map.**
  - P1: w up, s down, a left, d right, space (0x20) fire.
  - P2: i up, k down, j left, l right, Enter (0x0D) fire.
  - Control: p toggles pause; r restarts.
  - All other codes are ignored.
- **Event detect.**
  - Register {press, ascii} into s0, then s0 into s1.
  - An event is a cycle where s0 != s1 and s0.ascii != 0.
  - Repeated identical make codes (typematic) are not events. At most one event per cycle.
- **Held state.** 5-bit held mask per player (4 directions plus fire). A make event sets the bit; a break event clears it. The mask is tracked even while paused.
- **Direction make event:**
  - dir <= that direction.
  - Move pulse next cycle unless paused.
  - Move counter cleared to 0.
- **Direction break event:**
  - If the released key equals the current dir and other directions are still held, dir <= highest-priority held direction (up > down > left > right). No extra pulse; the counter keeps running.
  - If no direction is held, dir holds its last value, the counter is cleared and moves stop.
- **Move repeat.** While any direction is held and not paused, the counter increments each cycle. On reaching MOVE_DIV-1 it wraps to 0 and the move pulse fires. While paused the counter holds its value.
- **Fire.**
  - A fire make event with cooldown == 0 and not paused gives a fire pulse next cycle and cooldown <= FIRE_COOLDOWN.
  - A fire make event with cooldown != 0 or while paused is dropped, not queued.
  - Holding fire never auto-repeats.
  - Cooldown decrements to 0 every cycle, including while paused.
- **Pause.** A p make event toggles `paused`; a p break is ignored.
- **Restart.** An r make event pulses `game_rst` and clears, on the same edge:
  - held masks, move counters and cooldowns;
  - `paused`;
  - both dirs to 00.
- **Concurrency.** Player channels are independent; p1 and p2 pulses may coincide.
- **Counter widths.** Counters are $clog2-sized for their parameter. Arithmetic never overflows: the move counter wraps at MOVE_DIV-1 and cooldown saturates at 0.

## Timing
- **Reset.** While `clrn` = 0, all outputs are 0, dirs are 00, s0/s1 are 0, and masks, counters and cooldowns are 0. Release takes effect at the next edge.
- **Latency.** Input change sampled at edge E1 (into s0), so the event is visible in the cycle after E1. The resulting pulse or level change is registered at edge E2 and is high for exactly one cycle.
- **Move spacing.** After the initial press pulse, subsequent move pulses are exactly MOVE_DIV cycles apart.
- **Fire spacing.** A fire event accepted at edge E2 blocks further fire events whose pulse would land before edge E2 + FIRE_COOLDOWN.
- **Reset mid-operation.** Asynchronous reset aborts any pending pulse immediately.

## Test plan
All directed tests use MOVE_DIV = 8 and FIRE_COOLDOWN = 20.
1. **Reset.** Assert `clrn` = 0 mid-stream with w held -> all outputs 0 and dirs 00 immediately. After release, a new w make gives `p1_move` 2 edges later.
2. **Held direction.** Drive press=1, ascii=0x77 (w) and hold 40 cycles -> `p1_dir`=00; `p1_move` at +2 edges, then every 8 cycles (5 pulses total); `p2_move` stays 0.
3. **Direction fallback.**
   - d make then a make -> `p1_dir`=10 with an immediate pulse.
   - a break -> `p1_dir`=11, no extra pulse.
   - d break -> moves stop.
4. **Fire cooldown.**
   - Space make -> `p1_fire` pulse.
   - Break, then re-make 10 cycles later -> no pulse.
   - Re-make 25 cycles after the first -> pulse.
   - Enter make at the same time -> `p2_fire` unaffected by P1's cooldown.
5. **Pause.**
   - p make -> `paused`=1. i make now gives no `p2_move`, but the held mask is updated.
   - p break, then p make -> `paused`=0; `p2_move` resumes at the held counter phase with `p2_dir`=00.
6. **Restart and typematic.**
   - Three identical w make codes produce only one event.
   - r make -> `game_rst` single pulse; masks clear, dirs 00, `paused` 0, no further moves.
